ifetch_sequencer: RTL and testbench

//  Instruction-fetch sequencer for the RV32E core. Owns the program counter and drives the

---
 rtl/ifetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_ifetch_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_sequencer.sv
// ---------------------------------------------------------------------------
// ifetch_sequencer
//
// Instruction-fetch sequencer for the RV32E core. Owns the program counter,
// addresses a combinational program ROM (read data returns in the same
// cycle) and registers each fetched word together with its PC into a
// one-entry output stage guarded by a valid/ready handshake. Execute can
// redirect the PC; a redirect always flushes the output stage. A misaligned
// redirect target puts the sequencer into a sticky FAULT state that only
// reset leaves.
//
// Optional feature macro: FETCH_BOUNDS_EN
//   defined   : fetching at pc >= ROM_WORDS*4 enters FAULT (out_pc = pc)
//   undefined : such fetches deliver NOP_WORD instead of rom_data and carry
//               on normally
//
// Parameters
//   RESET_PC   PC loaded at reset (word-aligned)
//   ROM_WORDS  number of 32-bit ROM words
//   NOP_WORD   out_instr value at reset and on fault
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous active-low reset
//   rom_addr        out  byte address to ROM, always equal to pc
//   rom_data        in   ROM read data for rom_addr, same cycle
//   redirect_valid  in   execute requests a PC change this cycle
//   redirect_pc     in   redirect target byte address
//   out_valid       out  output stage holds a fetched instruction
//   out_ready       in   decode accepts when out_valid && out_ready
//   out_instr       out  fetched instruction word
//   out_pc          out  byte address of out_instr
//   fault           out  sticky fetch fault, fetch halted until reset
// ---------------------------------------------------------------------------
module ifetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 513,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        valid_next;
    logic [31:0] instr_next;
    logic [31:0] opc_next;

    logic        load;
    logic        beyond_rom;
    logic        misaligned;

    assign rom_addr   = pc;
    assign fault      = (state == FAULT);

    // The output stage can take a new word when it is empty or being drained.
    assign load       = !out_valid || out_ready;
    assign beyond_rom = (pc >= ROM_BYTES);
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= NOP_WORD;
            out_pc    <= RESET_PC;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            out_valid <= valid_next;
            out_instr <= instr_next;
            out_pc    <= opc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = out_valid;
        instr_next = out_instr;
        opc_next   = out_pc;

        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    // Redirect wins over a load and flushes the stage even
                    // when decode is accepting this cycle.
                    valid_next = 1'b0;
                    if (misaligned) begin
                        state_next = FAULT;
                        instr_next = NOP_WORD;
                        opc_next   = redirect_pc;
                    end else begin
                        pc_next = redirect_pc;
                    end
                end else if (load) begin
`ifdef FETCH_BOUNDS_EN
                    if (beyond_rom) begin
                        state_next = FAULT;
                        valid_next = 1'b0;
                        instr_next = NOP_WORD;
                        opc_next   = pc;
                    end else begin
                        valid_next = 1'b1;
                        instr_next = rom_data;
                        opc_next   = pc;
                        pc_next    = pc + 32'd4;
                    end
`else
                    // Out-of-range fetches read as NOP rather than whatever
                    // the ROM returns past its end.
                    valid_next = 1'b1;
                    instr_next = beyond_rom ? NOP_WORD : rom_data;
                    opc_next   = pc;
                    pc_next    = pc + 32'd4;
`endif
                end
            end
            FAULT: begin
                // Frozen: pc and output stage hold, nothing is offered.
                valid_next = 1'b0;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_ifetch_sequencer.sv
module tb_ifetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int n_cmp;
    int n_bad;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(513),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM word i holds ADDI x1,x0,i; reads past the last word return a
    // marker pattern so NOP substitution is visible.
    always_comb begin
        if (rom_addr < 32'd2052)
            rom_data = ({20'd0, rom_addr[13:2]} << 20) | 32'h0000_0093;
        else
            rom_data = 32'hDEAD_BEEF;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;

        // 1: reset state, then streaming with out_ready=1
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, NOP);
        check("rst_pc", out_pc, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_romaddr", rom_addr, 32'h0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("s1_valid0", {31'd0, out_valid}, 32'd1);
        check("s1_pc0", out_pc, 32'h0);
        check("s1_instr0", out_instr, 32'h0000_0093);
        step();
        check("s1_pc1", out_pc, 32'h4);
        check("s1_instr1", out_instr, 32'h0010_0093);
        step();
        check("s1_pc2", out_pc, 32'h8);
        check("s1_instr2", out_instr, 32'h0020_0093);
        check("s1_valid2", {31'd0, out_valid}, 32'd1);

        // 2: stall for 3 cycles after the first valid
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        step();
        check("s2_first_pc", out_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("s2_hold_pc", out_pc, 32'h0);
            check("s2_hold_romaddr", rom_addr, 32'h4);
            check("s2_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        check("s2_rel_pc4", out_pc, 32'h4);
        step();
        check("s2_rel_pc8", out_pc, 32'h8);

        // 3: redirect while stalled
        out_ready = 1'b0;
        step();
        check("s3_stall_pc", out_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        check("s3_flush_valid", {31'd0, out_valid}, 32'd0);
        check("s3_romaddr", rom_addr, 32'h40);
        redirect_valid = 1'b0;
        step();
        check("s3_tgt_valid", {31'd0, out_valid}, 32'd1);
        check("s3_tgt_pc", out_pc, 32'h40);
        check("s3_tgt_instr", out_instr, 32'h0100_0093);

        // 3b: redirect with out_ready=1 still flushes
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        step();
        check("s3b_flush_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        check("s3b_tgt_pc", out_pc, 32'h10);
        check("s3b_tgt_instr", out_instr, 32'h0040_0093);

        // 4: misaligned redirect -> sticky fault
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        step();
        check("s4_fault", {31'd0, fault}, 32'd1);
        check("s4_valid", {31'd0, out_valid}, 32'd0);
        check("s4_pc", out_pc, 32'h42);
        check("s4_instr", out_instr, NOP);
        check("s4_romaddr", rom_addr, 32'h14);
        redirect_pc = 32'h0;
        step();
        check("s4_ign_fault", {31'd0, fault}, 32'd1);
        check("s4_ign_pc", out_pc, 32'h42);
        check("s4_ign_romaddr", rom_addr, 32'h14);
        check("s4_ign_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("s4_rst_fault", {31'd0, fault}, 32'd0);
        check("s4_rst_romaddr", rom_addr, 32'h0);

        // 5: fetch past the end of the ROM
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h804;
        step();
        check("s5_redir_valid", {31'd0, out_valid}, 32'd0);
        check("s5_redir_fault", {31'd0, fault}, 32'd0);
        redirect_valid = 1'b0;
        step();
`ifdef FETCH_BOUNDS_EN
        check("s5_fault", {31'd0, fault}, 32'd1);
        check("s5_pc", out_pc, 32'h804);
        check("s5_valid", {31'd0, out_valid}, 32'd0);
        check("s5_instr", out_instr, NOP);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`else
        check("s5_valid", {31'd0, out_valid}, 32'd1);
        check("s5_pc", out_pc, 32'h804);
        check("s5_instr", out_instr, NOP);
        check("s5_fault", {31'd0, fault}, 32'd0);
        step();
        check("s5_next_pc", out_pc, 32'h808);
        check("s5_next_instr", out_instr, NOP);
`endif

        // 5b: last ROM word is still a real fetch
        redirect_valid = 1'b1;
        redirect_pc = 32'h800;
        step();
        redirect_valid = 1'b0;
        step();
        check("s5b_pc", out_pc, 32'h800);
        check("s5b_instr", out_instr, 32'h2000_0093);
        check("s5b_fault", {31'd0, fault}, 32'd0);

`ifndef FETCH_BOUNDS_EN
        // 5c: pc increment wraps modulo 2^32
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("s5c_pc", out_pc, 32'hFFFF_FFFC);
        check("s5c_wrap_romaddr", rom_addr, 32'h0);
        step();
        check("s5c_wrap_pc", out_pc, 32'h0);
        check("s5c_wrap_instr", out_instr, 32'h0000_0093);
`endif

        // 6: reset mid-stream overrides a redirect
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        check("s6_romaddr", rom_addr, 32'h0);
        check("s6_valid", {31'd0, out_valid}, 32'd0);
        check("s6_pc", out_pc, 32'h0);
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        step();
        check("s6_restart_pc", out_pc, 32'h0);
        check("s6_restart_instr", out_instr, 32'h0000_0093);
        check("s6_restart_valid", {31'd0, out_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
